// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder
//   AHB-Lite subordinate in front of a single-port synchronous SRAM.
//   Reads go to the SRAM straight from the address phase, so they never stall.
//   Writes are parked in a one-entry write buffer and drained in the next cycle
//   that has no read address phase. A read that hits the parked word is merged
//   with the buffer bytes. One exclusive-access reservation is kept for
//   hexcl/hexokay load-linked/store-conditional support.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   ahbls_hready .. hwdata    AHB-Lite subordinate request side
//   ahbls_hready_resp, hresp  transfer response (zero wait, or two-cycle error)
//   ahbls_hexokay             exclusive access okay, valid in data phase
//   ahbls_hrdata              read data, valid in data phase
//   sram_addr/ce/we/wbe/wdata SRAM request, at most one access per cycle
//   sram_rdata                SRAM read data, one cycle after a ce read
module ahb_sram_responder #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ahbls_hready,
    input  logic                     ahbls_hsel,
    input  logic [W_ADDR-1:0]        ahbls_haddr,
    input  logic                     ahbls_hwrite,
    input  logic [1:0]               ahbls_htrans,
    input  logic [2:0]               ahbls_hsize,
    input  logic                     ahbls_hexcl,
    input  logic [7:0]               ahbls_hmaster,
    input  logic [W_DATA-1:0]        ahbls_hwdata,
    output logic                     ahbls_hready_resp,
    output logic                     ahbls_hresp,
    output logic                     ahbls_hexokay,
    output logic [W_DATA-1:0]        ahbls_hrdata,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [3:0]               sram_wbe,
    output logic [31:0]              sram_wdata,
    input  logic [31:0]              sram_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic          aph, aph_err, aph_rd, aph_wr, misalign, res_match;
    logic [AW-1:0] aph_word;
    logic [3:0]    aph_wbe;

    // Control state (reset)
    logic          err1_q, err1_d, err2_q, err2_d;
    logic          rd_dph_q, rd_dph_d, wr_dph_q, wr_dph_d, exok_q, exok_d;
    logic          buf_valid_q, buf_valid_d, res_valid_q, res_valid_d;
    // Data state (no reset)
    logic [AW-1:0] dph_addr_q, dph_addr_d, buf_addr_q, buf_addr_d, res_addr_q, res_addr_d;
    logic [3:0]    dph_wbe_q, dph_wbe_d, buf_wbe_q, buf_wbe_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic [7:0]    res_master_q, res_master_d;

    logic unused_htrans0;
    assign unused_htrans0 = ahbls_htrans[0];

    // Address phase decode; reset masks acceptance so the SRAM is idle in reset.
    assign aph      = !rst && ahbls_hready && ahbls_hsel && ahbls_htrans[1];
    assign aph_word = ahbls_haddr[AW+1:2];

    always_comb begin
        misalign = 1'b0;
        aph_wbe  = 4'b0000;
        case (ahbls_hsize)
            3'd0: aph_wbe = 4'b0001 << ahbls_haddr[1:0];
            3'd1: begin
                misalign = ahbls_haddr[0];
                aph_wbe  = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                misalign = |ahbls_haddr[1:0];
                aph_wbe  = 4'b1111;
            end
            default: ;
        endcase
    end

    assign aph_err = aph && ((ahbls_haddr[W_ADDR-1:2] >= (W_ADDR-2)'(DEPTH))
                             || (ahbls_hsize > 3'd2) || misalign);
    assign aph_rd    = aph && !aph_err && !ahbls_hwrite;
    assign aph_wr    = aph && !aph_err &&  ahbls_hwrite;
    assign res_match = res_valid_q && (res_master_q == ahbls_hmaster) && (res_addr_q == aph_word);

    always_comb begin
        err1_d       = aph_err;
        err2_d       = err1_q;
        rd_dph_d     = aph_rd;
        // A failed exclusive write still gets a data phase, but never loads the buffer.
        wr_dph_d     = aph_wr && !(ahbls_hexcl && !res_match);
        exok_d       = ahbls_hexcl && (aph_rd || (aph_wr && res_match));
        dph_addr_d   = aph ? aph_word : dph_addr_q;
        dph_wbe_d    = aph ? aph_wbe  : dph_wbe_q;

        // Drain whenever the SRAM port is not claimed by a read.
        buf_valid_d  = buf_valid_q && aph_rd;
        buf_addr_d   = buf_addr_q;
        buf_wbe_d    = buf_wbe_q;
        buf_data_d   = buf_data_q;
        // The preceding write address phase drained the buffer, so loading never overwrites.
        if (wr_dph_q) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = dph_addr_q;
            buf_wbe_d   = dph_wbe_q;
            buf_data_d  = ahbls_hwdata[31:0];
        end

        res_valid_d  = res_valid_q;
        res_master_d = res_master_q;
        res_addr_d   = res_addr_q;
        if (aph_rd && ahbls_hexcl) begin
            res_valid_d  = 1'b1;
            res_master_d = ahbls_hmaster;
            res_addr_d   = aph_word;
        end else if (aph_wr && (ahbls_hexcl || res_addr_q == aph_word)) begin
            res_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
            rd_dph_q    <= 1'b0;
            wr_dph_q    <= 1'b0;
            exok_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            err1_q      <= err1_d;
            err2_q      <= err2_d;
            rd_dph_q    <= rd_dph_d;
            wr_dph_q    <= wr_dph_d;
            exok_q      <= exok_d;
            buf_valid_q <= buf_valid_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        dph_addr_q   <= dph_addr_d;
        dph_wbe_q    <= dph_wbe_d;
        buf_addr_q   <= buf_addr_d;
        buf_wbe_q    <= buf_wbe_d;
        buf_data_q   <= buf_data_d;
        res_master_q <= res_master_d;
        res_addr_q   <= res_addr_d;
    end

    // SRAM port: a read address phase has priority over the buffer drain.
    assign sram_ce    = aph_rd || buf_valid_q;
    assign sram_we    = !aph_rd && buf_valid_q;
    assign sram_addr  = aph_rd ? aph_word : buf_addr_q;
    assign sram_wbe   = aph_rd ? 4'b0000 : buf_wbe_q;
    assign sram_wdata = buf_data_q;

    assign ahbls_hready_resp = !err1_q;
    assign ahbls_hresp       = err1_q || err2_q;
    assign ahbls_hexokay     = exok_q;

    // Read data: bytes still parked in the buffer override stale SRAM lanes.
    always_comb begin
        ahbls_hrdata = sram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (rd_dph_q && buf_valid_q && (buf_addr_q == dph_addr_q) && buf_wbe_q[i])
                ahbls_hrdata[8*i +: 8] = buf_data_q[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_responder.sv
module tb_ahb_sram_responder;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          hready, hsel, hwrite, hexcl;
    logic [31:0]   haddr, hwdata;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [7:0]    hmaster;
    logic          hready_resp, hresp, hexokay;
    logic [31:0]   hrdata;
    logic [AW-1:0] sram_addr;
    logic          sram_ce, sram_we;
    logic [3:0]    sram_wbe;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 32'h0;

    always #5 clk = ~clk;

    ahb_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ahbls_hready(hready), .ahbls_hsel(hsel), .ahbls_haddr(haddr),
        .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsize(hsize),
        .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster), .ahbls_hwdata(hwdata),
        .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
        .ahbls_hexokay(hexokay), .ahbls_hrdata(hrdata),
        .sram_addr(sram_addr), .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_wbe(sram_wbe), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Synchronous SRAM model with a one-time preload.
    logic [31:0] mem [DEPTH];
    bit          preload_done = 1'b0;
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            mem[8] <= 32'h11223344;
            preload_done <= 1'b1;
        end else if (sram_ce === 1'b1) begin
            if (sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wbe[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        resp;
        logic        exok;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  last_ce;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic sel, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic excl, input logic [7:0] mst,
                         input logic [31:0] wdata);
        hready  = rdy;
        hsel    = sel;
        htrans  = sel ? 2'b10 : 2'b00;
        haddr   = addr;
        hwrite  = wr;
        hsize   = size;
        hexcl   = excl;
        hmaster = mst;
        hwdata  = wdata;
    endtask

    // kind: 0 okay, 1 okay with read data check, 2 error (two response cycles), 3 stall cycle
    task automatic step(input string tag, input logic sel, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic excl, input logic [7:0] mst,
                        input logic [31:0] wdata, input int kind, input logic [31:0] erd,
                        input logic eexok);
        exp_t  e;
        string t;
        drive(kind != 3, sel, addr, wr, size, excl, mst, wdata);
        @(negedge clk);
        last_ce = sram_ce;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            chk({t, "_hready"}, {31'b0, hready_resp}, {31'b0, e.rdy});
            chk({t, "_hresp"}, {31'b0, hresp}, {31'b0, e.resp});
            chk({t, "_hexokay"}, {31'b0, hexokay}, {31'b0, e.exok});
            if (e.chk_rd) chk({t, "_hrdata"}, hrdata, e.rdata);
        end
        if (kind == 2) begin
            expq.push_back('{rdy: 1'b0, resp: 1'b1, exok: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
            tagq.push_back({tag, "_c1"});
            expq.push_back('{rdy: 1'b1, resp: 1'b1, exok: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
            tagq.push_back({tag, "_c2"});
        end else if (kind != 3) begin
            expq.push_back('{rdy: 1'b1, resp: 1'b0, exok: eexok, chk_rd: (kind == 1), rdata: erd});
            tagq.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed still running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 3'd2, 1'b0, 8'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready", {31'b0, hready_resp}, 32'd1);
        chk("rst_hresp", {31'b0, hresp}, 32'd0);
        chk("rst_hexokay", {31'b0, hexokay}, 32'd0);
        chk("rst_ce", {31'b0, sram_ce}, 32'd0);
        chk("rst_we", {31'b0, sram_we}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then back-to-back read of the same word: served from the buffer.
        step("w10", 1, 32'h10, 1, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        step("r10", 1, 32'h10, 0, 3'd2, 0, 8'd0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
        step("idle_a", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        chk("mem_0x10", mem[4], 32'hDEADBEEF);

        // Byte write then word read: merge of buffer lane with SRAM data.
        step("wb21", 1, 32'h21, 1, 3'd0, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        step("r20", 1, 32'h20, 0, 3'd2, 0, 8'd0, 32'h5566AA77, 1, 32'h1122AA44, 0);
        step("idle_b", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        chk("mem_0x20", mem[8], 32'h1122AA44);

        // Error responses: out of range, misaligned halfword, oversize.
        step("err_oor", 1, DEPTH * 4, 0, 3'd2, 0, 8'd0, 32'h0, 2, 32'h0, 0);
        chk("err_oor_ce0", {31'b0, last_ce}, 32'd0);
        step("stall_a", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 3, 32'h0, 0);
        chk("err_oor_ce1", {31'b0, last_ce}, 32'd0);
        step("idle_c", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        chk("err_oor_ce2", {31'b0, last_ce}, 32'd0);
        step("err_h3", 1, 32'h3, 0, 3'd1, 0, 8'd0, 32'h0, 2, 32'h0, 0);
        chk("err_h3_ce0", {31'b0, last_ce}, 32'd0);
        step("stall_b", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 3, 32'h0, 0);
        chk("err_h3_ce1", {31'b0, last_ce}, 32'd0);
        step("idle_d", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        step("err_sz", 1, 32'h0, 0, 3'd3, 0, 8'd0, 32'h0, 2, 32'h0, 0);
        chk("err_sz_ce0", {31'b0, last_ce}, 32'd0);
        step("stall_c", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 3, 32'h0, 0);
        step("idle_e", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);

        // Exclusive pair succeeds once; repeated exclusive write fails.
        step("xr40", 1, 32'h40, 0, 3'd2, 1, 8'd0, 32'h0, 1, 32'h0, 1);
        step("xw40", 1, 32'h40, 1, 3'd2, 1, 8'd0, 32'h0, 0, 32'h0, 1);
        step("xw40b", 1, 32'h40, 1, 3'd2, 1, 8'd0, 32'hCAFEF00D, 0, 32'h0, 0);
        step("idle_f", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h12345678, 0, 32'h0, 0);
        step("idle_g", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        chk("mem_0x40_a", mem[16], 32'hCAFEF00D);
        step("r40", 1, 32'h40, 0, 3'd2, 0, 8'd0, 32'h0, 1, 32'hCAFEF00D, 0);

        // Another master's plain write kills the reservation.
        step("xr40_m0", 1, 32'h40, 0, 3'd2, 1, 8'd0, 32'h0, 1, 32'hCAFEF00D, 1);
        step("w40_m1", 1, 32'h40, 1, 3'd2, 0, 8'd1, 32'h0, 0, 32'h0, 0);
        step("xw40_m0", 1, 32'h40, 1, 3'd2, 1, 8'd0, 32'hB1B1B1B1, 0, 32'h0, 0);
        step("idle_h", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0BAD0BAD, 0, 32'h0, 0);
        step("idle_i", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        chk("mem_0x40_b", mem[16], 32'hB1B1B1B1);

        // Reset during a write data phase (with a read being presented).
        step("w50", 1, 32'h50, 1, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        drive(1'b1, 1'b1, 32'h10, 1'b0, 3'd2, 1'b0, 8'd0, 32'h77777777);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_hready", {31'b0, hready_resp}, 32'd1);
        chk("mid_rst_hresp", {31'b0, hresp}, 32'd0);
        chk("mid_rst_hexokay", {31'b0, hexokay}, 32'd0);
        chk("mid_rst_ce", {31'b0, sram_ce}, 32'd0);
        chk("mid_rst_we", {31'b0, sram_we}, 32'd0);
        expq.delete();
        tagq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("r50", 1, 32'h50, 0, 3'd2, 0, 8'd0, 32'h0, 1, 32'h0, 0);
        step("r10_post", 1, 32'h10, 0, 3'd2, 0, 8'd0, 32'h0, 1, 32'hDEADBEEF, 0);
        step("idle_j", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        step("idle_k", 0, 32'h0, 0, 3'd2, 0, 8'd0, 32'h0, 0, 32'h0, 0);
        chk("mem_0x50", mem[20], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_responder.md
AHB_SRAM_RESPONDER -- requirements
Module: ahb_sram_responder

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, the AHB address width.
REQ-002 SHALL have parameter W_DATA, default 32, the data width; only 32 is supported.
REQ-003 SHALL have parameter DEPTH, default 1024, the SRAM size in 32-bit words (power of 2).
REQ-004 SHALL have port clk  in  1  the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have AHB-Lite subordinate inputs: ahbls_hready (1, bus ready), ahbls_hsel (1), ahbls_haddr (W_ADDR), ahbls_hwrite (1), ahbls_htrans (2), ahbls_hsize (3), ahbls_hexcl (1), ahbls_hmaster (8), ahbls_hwdata (W_DATA).
REQ-007 SHALL have AHB-Lite subordinate outputs: ahbls_hready_resp (1), ahbls_hresp (1), ahbls_hexokay (1), ahbls_hrdata (W_DATA).
REQ-008 SHALL have synchronous SRAM ports: sram_addr out log2(DEPTH), sram_ce out 1, sram_we out 1, sram_wbe out 4 (byte enables), sram_wdata out 32, sram_rdata in 32 (valid one cycle after a ce read).

Function
REQ-009 SHALL accept an address phase ("aph") when ahbls_hready && ahbls_hsel && ahbls_htrans[1]; the data phase ("dph") is the following cycle(s).
REQ-010 SHALL flag an aph as erroneous if haddr[W_ADDR-1:2] offset >= DEPTH, hsize > 2, or haddr misaligned for hsize.
REQ-011 SHALL answer an erroneous aph with a two-cycle error: dph cycle 1 hready_resp=0, hresp=1; cycle 2 hready_resp=1, hresp=1; no SRAM access and no state change other than buffer flush.
REQ-012 SHALL answer all non-error transfers with zero wait states (hready_resp=1, hresp=0).
REQ-013 SHALL for a read aph drive sram_ce=1, sram_we=0, sram_addr=haddr word index combinationally; ahbls_hrdata in dph = sram_rdata merged with the write buffer per REQ-016.
REQ-014 SHALL for a write aph register word address and byte enables (hsize 0/1/2 -> 1/2/4 lanes selected by haddr[1:0]); in dph, capture hwdata into a single-entry write buffer at the end of the dph cycle (buf_valid=1).
REQ-015 SHALL flush the write buffer (sram_ce=1, sram_we=1, sram_wbe, sram_wdata from buffer; buf_valid=0) in every cycle with no read aph accepted; a write aph is always such a cycle, so the buffer is empty when a new write reaches dph.
REQ-016 SHALL in read dph, if buf_valid and buffer word address equals the read word address, return buffer bytes in lanes whose buffer byte enable is set and sram_rdata elsewhere, using buffer contents as registered at start of that cycle.
REQ-017 SHALL hold one exclusive reservation {valid, hmaster, word address}; an accepted exclusive read (hexcl=1, non-error) sets it and returns hexokay=1 in dph.
REQ-018 SHALL on an accepted exclusive write: succeed if reservation valid with matching hmaster and word address (hexokay=1 in dph, write proceeds); else fail (hexokay=0, hresp=0, buffer not loaded, SRAM unchanged); reservation cleared in both cases.
REQ-019 SHALL clear the reservation on any successful non-exclusive write to the reserved word, from any master.
REQ-020 SHALL drive hexokay=0 for all non-exclusive transfers and error responses.
REQ-021 SHALL never stall reads for buffer flush; SRAM sees at most one access per cycle.

Reset
REQ-022 SHALL on rst asynchronously set: hready_resp=1, hresp=0, hexokay=0, sram_ce=0, sram_we=0, buf_valid=0, reservation valid=0, dph-active and error state idle.
REQ-023 SHALL discard any transfer in flight at reset, including an unflushed buffered write (its SRAM contents undefined-by-spec only for that word).

Verification
REQ-024 SHALL pass: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> hrdata=0xDEADBEEF from buffer bypass, zero wait states.
REQ-025 SHALL pass: word 0x20 holds 0x11223344; byte write 0xAA to 0x21, immediate read 0x20 -> 0x1122AA44; after one idle cycle SRAM word 0x20 = 0x1122AA44.
REQ-026 SHALL pass: read at offset DEPTH*4 -> hready_resp 0 then 1 with hresp=1 both cycles, sram_ce=0 throughout; same for halfword at 0x3.
REQ-027 SHALL pass: master 0 exclusive read 0x40 (hexokay=1), exclusive write 0x40 -> hexokay=1, data written; repeat write -> hexokay=0, memory unchanged.
REQ-028 SHALL pass: master 0 exclusive read 0x40, master 1 plain write 0x40, master 0 exclusive write 0x40 -> hexokay=0, memory holds master 1 data.
REQ-029 SHALL pass: assert rst during a write dph -> all outputs at reset values immediately, buf_valid=0, next read accepted normally.
